// File: rtl/fetch_pkg.sv
// fetch_pkg: constants shared by the instruction fetch stage and decode.
//   NOP_WORD_DEFAULT   : bubble word placed in IF/ID (sll $zero,$zero,0)
//   RESET_PC_DEFAULT   : default PC after reset
//   IMEM_DEPTH_DEFAULT : default instruction memory depth in words
//   PC_BITS            : significant PC bits for the default depth
//   OP_J/OP_BEQ/OP_BNE : control-flow opcodes, decoded in ID
package fetch_pkg;

    localparam logic [31:0] NOP_WORD_DEFAULT   = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam int          IMEM_DEPTH_DEFAULT = 256;
    localparam int          PC_BITS            = $clog2(IMEM_DEPTH_DEFAULT);

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

endpackage

// File: rtl/if_id_register.sv
// if_id_register: IF/ID pipeline register.
//   clk, rst         : clock and synchronous active-high reset
//   bubble           : load NOP_WORD, PC+1 = 0, valid = 0
//   load             : capture instruction_in / pc_plus1_in as a valid entry
//   (neither)        : hold
//   instruction      : registered instruction
//   pc_plus1         : registered PC+1 of that instruction
//   valid            : entry is a real fetch, not a bubble
module if_id_register
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bubble,
    input  logic        load,
    input  logic [31:0] instruction_in,
    input  logic [31:0] pc_plus1_in,
    output logic [31:0] instruction,
    output logic [31:0] pc_plus1,
    output logic        valid
);

    // Reset and bubble leave the register in the same empty state.
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            instruction <= NOP_WORD;
            pc_plus1    <= 32'd0;
            valid       <= 1'b0;
        end else if (load) begin
            instruction <= instruction_in;
            pc_plus1    <= pc_plus1_in;
            valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: program counter, next-PC selection and IF/ID register.
//   Clock, Reset      : rising-edge clock, synchronous active-high reset
//   Stall             : hold PC and IF/ID
//   Flush             : turn IF/ID into a bubble
//   BranchTaken       : taken beq/bne resolved in ID, offset in BranchOffset
//   Jump              : j resolved in ID, instr_index in JumpTarget
//   Instruction       : combinational instruction memory data at ReadAddress
//   ReadAddress       : current PC (word address)
//   IfIdInstruction   : registered instruction for decode
//   IfIdPcPlus1       : registered PC+1 of IfIdInstruction
//   IfIdValid         : IfIdInstruction is a real fetch
module instruction_fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
    parameter logic [31:0] NOP_WORD   = NOP_WORD_DEFAULT
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        BranchTaken,
    input  logic [15:0] BranchOffset,
    input  logic        Jump,
    input  logic [25:0] JumpTarget,
    input  logic [31:0] Instruction,
    output logic [31:0] ReadAddress,
    output logic [31:0] IfIdInstruction,
    output logic [31:0] IfIdPcPlus1,
    output logic        IfIdValid
);

    localparam int          PC_W    = $clog2(IMEM_DEPTH);
    localparam logic [31:0] PC_MASK = (32'd1 << PC_W) - 32'd1;

    // All PC arithmetic is done at 32 bits and then wrapped to the memory depth.
    function automatic logic [31:0] wrap_pc(input logic [31:0] addr);
        return addr & PC_MASK;
    endfunction

    logic        [31:0] pc;
    logic        [31:0] pc_next;
    logic        [31:0] pc_plus1;
    logic        [31:0] branch_target;
    logic        [31:0] jump_addr;
    logic signed [31:0] branch_offset_ext;
    logic               take_jump;
    logic               take_branch;
    logic               ifid_bubble;
    logic               ifid_load;

    assign branch_offset_ext = 32'(signed'(BranchOffset));
    assign pc_plus1          = wrap_pc(pc + 32'd1);
    assign branch_target     = wrap_pc(IfIdPcPlus1 + branch_offset_ext);
    assign jump_addr         = wrap_pc({IfIdPcPlus1[31:26], JumpTarget});

    // A redirect decoded from a bubble is stale and must not steer the PC.
    assign take_jump   = Jump && IfIdValid;
    assign take_branch = BranchTaken && IfIdValid && !Jump;

    assign ifid_bubble = take_jump || take_branch || Flush;
    assign ifid_load   = !Stall;

    always_comb begin
        pc_next = pc_plus1;
        if (take_jump) begin
            pc_next = jump_addr;
        end else if (take_branch) begin
            pc_next = branch_target;
        end else if (Stall) begin
            // Covers both plain stall and stall combined with flush.
            pc_next = pc;
        end
    end

    // ---- IF stage: PC register ----
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc <= wrap_pc(RESET_PC);
        end else begin
            pc <= pc_next;
        end
    end

    assign ReadAddress = pc;

    // ---- IF/ID boundary ----
    if_id_register #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id (
        .clk            (Clock),
        .rst            (Reset),
        .bubble         (ifid_bubble),
        .load           (ifid_load),
        .instruction_in (Instruction),
        .pc_plus1_in    (pc_plus1),
        .instruction    (IfIdInstruction),
        .pc_plus1       (IfIdPcPlus1),
        .valid          (IfIdValid)
    );

endmodule
